// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: tile encoding, switch-to-tile map, move sequencer states.
package ttt_pkg;

    localparam int unsigned NUM_TILES = 9;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P0    = 2'b01;
    localparam logic [1:0] P1    = 2'b10;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    // Indexed by switch number; gives the tile that switch selects.
    localparam logic [3:0] SW_TO_TILE [NUM_TILES] = '{
        4'd2, 4'd1, 4'd0, 4'd5, 4'd4, 4'd3, 4'd8, 4'd7, 4'd6
    };

    // Switch numbers, highest priority first.
    localparam logic [3:0] SW_PRIORITY [NUM_TILES] = '{
        4'd6, 4'd7, 4'd8, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2
    };

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StCommit,
        StUndo
    } seq_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] tile;
    } move_req_t;

    // Pick the single highest-priority rising switch; everything else is dropped.
    function automatic move_req_t select_move(input logic [NUM_TILES-1:0] rise);
        move_req_t req;
        req = '0;
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (rise[SW_PRIORITY[i]]) begin
                req.valid = 1'b1;
                req.tile  = SW_TO_TILE[SW_PRIORITY[i]];
            end
        end
        return req;
    endfunction

    function automatic logic [NUM_TILES-1:0] tile_onehot(input logic [3:0] tile);
        return NUM_TILES'(1) << tile;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus whole-vector debounce; emits one-cycle pulses on accepted rises.
module switch_debounce #(
    parameter int unsigned WIDTH           = 9,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] rise
);

    localparam int unsigned CntWidth = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]    sync1_q;
    logic [WIDTH-1:0]    sync2_q;
    logic [WIDTH-1:0]    last_q;
    logic [WIDTH-1:0]    deb_q;
    logic [WIDTH-1:0]    rise_q;
    logic [CntWidth-1:0] cnt_q;
    logic                primed_q;
    logic                stable;
    logic                accept;

    always_comb begin
        stable = (sync2_q == last_q);
        accept = stable && (cnt_q == CntMax);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            last_q   <= '0;
            deb_q    <= '0;
            rise_q   <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            rise_q  <= '0;
            if (!stable) begin
                last_q <= sync2_q;
                cnt_q  <= '0;
            end else if (accept) begin
                // The first pattern accepted after reset only establishes the baseline.
                deb_q    <= last_q;
                primed_q <= 1'b1;
                if (primed_q) begin
                    rise_q <= last_q & ~deb_q;
                end
            end else begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/move_sequencer.sv
// Turns debounced switch rises and undo requests into tile select/clear pulses with turn tracking.
module move_sequencer
    import ttt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_TILES-1:0] input_switches,
    input  logic                 undo_req,
    input  logic [17:0]          tiles,
    input  logic                 game_over,
    output logic [NUM_TILES-1:0] player_move,
    output logic [NUM_TILES-1:0] clear_tile,
    output logic                 current_turn,
    output logic [3:0]           move_count,
    output logic                 illegal
);

    logic [NUM_TILES-1:0] rise;

    switch_debounce #(
        .WIDTH          (NUM_TILES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .raw  (input_switches),
        .rise (rise)
    );

    seq_state_e state_q, state_d;
    logic [3:0] tile_q, tile_d;
    logic       turn_q, turn_d;
    logic [3:0] count_q, count_d;
    logic       illegal_q, illegal_d;
    logic       push;
    logic [3:0] stack_q [NUM_TILES];
    move_req_t  req;
    logic [1:0] tile_state;

    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        turn_d      = turn_q;
        count_d     = count_q;
        illegal_d   = 1'b0;
        push        = 1'b0;
        player_move = '0;
        clear_tile  = '0;
        req         = select_move(rise);
        tile_state  = tiles[{tile_q, 1'b0} +: 2];

        unique case (state_q)
            StIdle: begin
                // Undo wins over a coincident edge; the edge is simply lost.
                if (undo_req && (count_q != 4'd0)) begin
                    state_d = StUndo;
                    tile_d  = stack_q[count_q - 4'd1];
                end else if (req.valid) begin
                    state_d = StCheck;
                    tile_d  = req.tile;
                end
            end
            StCheck: begin
                if ((tile_state == EMPTY) && !game_over && (count_q != MAX_MOVES)) begin
                    state_d = StCommit;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StCommit: begin
                player_move = tile_onehot(tile_q);
                turn_d      = ~turn_q;
                count_d     = count_q + 4'd1;
                push        = 1'b1;
                state_d     = StIdle;
            end
            StUndo: begin
                clear_tile = tile_onehot(tile_q);
                turn_d     = ~turn_q;
                count_d    = count_q - 4'd1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            tile_q    <= '0;
            turn_q    <= 1'b0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            turn_q    <= turn_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // move_count doubles as the stack pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TILES; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push) begin
            stack_q[count_q] <= tile_q;
        end
    end

    assign current_turn = turn_q;
    assign move_count   = count_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with DEBOUNCE_CYCLES=4.
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  sw;
    logic        undo_req;
    logic [17:0] tiles;
    logic        game_over;
    logic [8:0]  player_move;
    logic [8:0]  clear_tile;
    logic        current_turn;
    logic [3:0]  move_count;
    logic        illegal;

    int          checks = 0;
    int          errors = 0;
    logic        exp_turn;
    logic [3:0]  exp_count;

    always #5 clk = ~clk;

    move_sequencer #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .input_switches(sw),
        .undo_req      (undo_req),
        .tiles         (tiles),
        .game_over     (game_over),
        .player_move   (player_move),
        .clear_tile    (clear_tile),
        .current_turn  (current_turn),
        .move_count    (move_count),
        .illegal       (illegal)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input string what, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    task automatic set_tile(input int idx, input logic [1:0] v);
        tiles[2*idx +: 2] = v;
    endtask

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cycles(1);
            check(tag, "no_pulse", {13'd0, player_move, clear_tile, illegal}, 32'd0);
        end
    endtask

    // Raise switches in mask; the pulse is due 9 cycles after the input changes.
    task automatic move_expect(input logic [8:0] mask, input logic [8:0] exp_pm,
                               input logic exp_ill, input string tag);
        sw = sw | mask;
        cycles(8);
        check(tag, "pre", {22'd0, player_move, illegal}, 32'd0);
        cycles(1);
        check(tag, "pm", {23'd0, player_move}, {23'd0, exp_pm});
        check(tag, "ill", {31'd0, illegal}, {31'd0, exp_ill});
        check(tag, "turn_during", {31'd0, current_turn}, {31'd0, exp_turn});
        cycles(1);
        if (exp_pm != 9'd0) begin
            exp_turn  = ~exp_turn;
            exp_count = exp_count + 4'd1;
        end
        check(tag, "post", {22'd0, player_move, illegal}, 32'd0);
        check(tag, "turn", {31'd0, current_turn}, {31'd0, exp_turn});
        check(tag, "count", {28'd0, move_count}, {28'd0, exp_count});
    endtask

    task automatic do_undo(input logic [8:0] exp_clear, input string tag);
        undo_req = 1'b1;
        cycles(1);
        undo_req = 1'b0;
        check(tag, "clear", {23'd0, clear_tile}, {23'd0, exp_clear});
        check(tag, "pm", {23'd0, player_move}, 32'd0);
        cycles(1);
        if (exp_clear != 9'd0) begin
            exp_turn  = ~exp_turn;
            exp_count = exp_count - 4'd1;
        end
        check(tag, "clear_after", {23'd0, clear_tile}, 32'd0);
        check(tag, "turn", {31'd0, current_turn}, {31'd0, exp_turn});
        check(tag, "count", {28'd0, move_count}, {28'd0, exp_count});
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, "pm", {23'd0, player_move}, 32'd0);
        check(tag, "clear", {23'd0, clear_tile}, 32'd0);
        check(tag, "ill", {31'd0, illegal}, 32'd0);
        check(tag, "turn", {31'd0, current_turn}, 32'd0);
        check(tag, "count", {28'd0, move_count}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        sw        = '0;
        undo_req  = 1'b0;
        tiles     = '0;
        game_over = 1'b0;
        exp_turn  = 1'b0;
        exp_count = 4'd0;

        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        quiet(10, "idle");
        check_all_zero("idle");

        // Single legal move on tile 4.
        move_expect(9'h010, 9'h010, 1'b0, "mv_t4");
        set_tile(4, 2'b01);
        sw[4] = 1'b0;
        quiet(10, "rel_sw4");

        // Occupied tile.
        move_expect(9'h010, 9'h000, 1'b1, "occ_t4");
        sw[4] = 1'b0;
        quiet(10, "rel_sw4b");

        // Tile 8 then two undos.
        move_expect(9'h040, 9'h100, 1'b0, "mv_t8");
        set_tile(8, 2'b10);
        do_undo(9'h100, "undo1");
        set_tile(8, 2'b00);
        do_undo(9'h010, "undo2");
        set_tile(4, 2'b00);
        sw[6] = 1'b0;
        quiet(10, "rel_sw6");

        // Simultaneous rises on switches 0 and 6: only tile 8.
        move_expect(9'h041, 9'h100, 1'b0, "prio");
        set_tile(8, 2'b01);
        quiet(12, "prio_rest");
        sw[0] = 1'b0;
        quiet(10, "rel_sw0");
        move_expect(9'h001, 9'h004, 1'b0, "mv_t2");
        set_tile(2, 2'b10);

        // Short glitch is filtered out.
        sw[3] = 1'b1;
        cycles(2);
        sw[3] = 1'b0;
        quiet(14, "glitch");

        // Game over: moves rejected, undo still honoured.
        game_over = 1'b1;
        move_expect(9'h020, 9'h000, 1'b1, "gameover");
        do_undo(9'h004, "undo_go");
        set_tile(2, 2'b00);
        game_over = 1'b0;
        sw[5] = 1'b0;
        quiet(10, "rel_sw5");

        // Reset in the middle of COMMIT.
        sw[7] = 1'b1;
        cycles(9);
        check("commit_rst", "pm_before", {23'd0, player_move}, 32'h080);
        check("commit_rst", "turn_before", {31'd0, current_turn}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("commit_rst");
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_turn  = 1'b0;
        exp_count = 4'd0;
        tiles     = '0;
        quiet(20, "post_rst");
        check("post_rst", "count", {28'd0, move_count}, 32'd0);

        // Undo with an empty stack is ignored.
        do_undo(9'h000, "undo_empty");

        sw = '0;
        quiet(10, "rel_all");

        // Fill the stack to nine moves.
        for (int i = 0; i < 9; i++) begin
            move_expect(9'h010, 9'h010, 1'b0, "fill");
            sw[4] = 1'b0;
            quiet(10, "fill_rel");
        end
        check("full", "count9", {28'd0, move_count}, 32'd9);
        move_expect(9'h010, 9'h000, 1'b1, "full");
        do_undo(9'h010, "undo_full");
        check("undo_full", "count8", {28'd0, move_count}, 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
